// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing for the iterative divider
package div_pkg;

    localparam int DIV_DEFAULT_WIDTH = 64;
    localparam int DIV_COUNT_W       = $clog2(DIV_DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    // Step counter width for an arbitrary operand width (never narrower than 1 bit).
    function automatic int div_count_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/iter_divider_if.sv
// rtl/iter_divider_if.sv - operand and result handshakes of the iterative divider
interface iter_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-and-subtract step
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] diff;

    // The partial remainder is always below the divisor, so the signed result
    // lies in (-divisor, divisor) and fits WIDTH+1 bits; diff[WIDTH] is its sign.
    assign diff    = {rem_i, dvd_bit_i} - {1'b0, divisor_i};
    assign q_bit_o = ~diff[WIDTH];
    assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : {rem_i[WIDTH-2:0], dvd_bit_i};

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional signed support and FIX state: ITER_DIVIDER_SIGNED_EN.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          reset_n,
    iter_divider_if.slave bus
);

`ifdef ITER_DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    localparam int            CW         = div_count_w(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             divisor_zero;
    logic             signed_op;
    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    assign accept       = bus.in_valid && bus.in_ready;
    assign divisor_zero = (bus.divisor == '0);
    assign signed_op    = SIGNED_EN && bus.is_signed;
    assign dvd_neg      = signed_op && bus.dividend[WIDTH-1];
    assign dsr_neg      = signed_op && bus.divisor[WIDTH-1];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = divisor_zero ? DONE : CALC;
            CALC: if (count_q == '0) state_d = SIGNED_EN ? FIX : DONE;
            FIX:  state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // The working dividend register shifts quotient bits in from the LSB, so it
    // ends up holding the quotient and drives the result port directly.
    always_comb begin
        count_d   = count_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    dbz_d = divisor_zero;
                    dsr_d = dsr_neg ? -bus.divisor : bus.divisor;
                    if (divisor_zero) begin
                        dvd_d     = '1;
                        rem_d     = bus.dividend;
                        quo_neg_d = 1'b0;
                        rem_neg_d = 1'b0;
                    end else begin
                        dvd_d     = dvd_neg ? -bus.dividend : bus.dividend;
                        rem_d     = '0;
                        quo_neg_d = dvd_neg ^ dsr_neg;
                        rem_neg_d = dvd_neg;
                        count_d   = LAST_COUNT;
                    end
                end
            end
            CALC: begin
                rem_d   = step_rem;
                dvd_d   = {dvd_q[WIDTH-2:0], step_q};
                count_d = (count_q == '0) ? '0 : count_q - CW'(1);
            end
            FIX: begin
                if (quo_neg_q) dvd_d = -dvd_q;
                if (rem_neg_q) rem_d = -rem_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.quotient    = dvd_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule
